// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: decodes the IF/ID instruction into main control,
// builds the sign-extended immediate, detects load-use hazards and registers
// everything into the ID/EX register with stall, flush and bubble support.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  output logic                  load_use_hazard,
  output logic                  ex_valid,
  output logic [1:0]            ex_alu_op,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_pc,
  output logic                  ex_illegal
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [1:0]            w_alu_op;
  logic                  w_reg_write;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_mem_to_reg;
  logic                  w_alu_src;
  logic                  w_branch;
  logic                  w_illegal;
  logic                  w_uses_rs2;
  logic [31:0]           w_imm32;
  logic [XLEN-1:0]       w_imm;

  logic                  r_valid;
  logic [1:0]            r_alu_op;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_to_reg;
  logic                  r_alu_src;
  logic                  r_branch;
  logic                  r_illegal;
  logic [2:0]            r_funct3;
  logic [6:0]            r_funct7;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [XLEN-1:0]       r_pc;

  assign w_opcode = id_instr[6:0];
  assign w_rs1    = REG_ADDR_W'(id_instr[19:15]);
  assign w_rs2    = REG_ADDR_W'(id_instr[24:20]);
  assign w_rd     = REG_ADDR_W'(id_instr[11:7]);
  assign w_imm    = XLEN'($signed(w_imm32));

  // Main decoder: opcode to control bits and the matching immediate format.
  always_comb begin
    w_alu_op     = 2'b00;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    w_uses_rs2   = 1'b0;
    w_imm32      = 32'h0;
    case (w_opcode)
      OP_RTYPE: begin
        w_alu_op    = 2'b10;
        w_reg_write = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OP_IARITH: begin
        w_alu_op    = 2'b11;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm32     = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_imm32      = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_uses_rs2  = 1'b1;
        w_imm32     = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      end
      OP_BRANCH: begin
        w_alu_op   = 2'b01;
        w_branch   = 1'b1;
        w_uses_rs2 = 1'b1;
        w_imm32    = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                      id_instr[30:25], id_instr[11:8], 1'b0};
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    if (w_rd == '0) begin
      w_reg_write = 1'b0;
    end
  end

  assign load_use_hazard = r_valid & r_mem_read & id_valid & (r_rd != '0) &
                           ((r_rd == w_rs1) | ((r_rd == w_rs2) & w_uses_rs2));

  // Control half of ID/EX: flush beats stall beats hazard bubble beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_alu_op     <= 2'b00;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (flush || (!stall && load_use_hazard)) begin
      r_valid      <= 1'b0;
      r_alu_op     <= 2'b00;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (!stall) begin
      r_valid      <= id_valid;
      r_alu_op     <= id_valid ? w_alu_op : 2'b00;
      r_reg_write  <= id_valid & w_reg_write;
      r_mem_read   <= id_valid & w_mem_read;
      r_mem_write  <= id_valid & w_mem_write;
      r_mem_to_reg <= id_valid & w_mem_to_reg;
      r_alu_src    <= id_valid & w_alu_src;
      r_branch     <= id_valid & w_branch;
      r_illegal    <= id_valid & w_illegal;
    end
  end

  // Data half of ID/EX: loads whenever not held; contents of bubbles are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
    end else if (flush || !stall) begin
      r_funct3   <= id_instr[14:12];
      r_funct7   <= id_instr[31:25];
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= w_imm;
      r_pc       <= id_pc;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_alu_op;
  assign ex_funct3     = r_funct3;
  assign ex_funct7     = r_funct7;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_alu_src    = r_alu_src;
  assign ex_branch     = r_branch;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_pc         = r_pc;
  assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: decode, immediates, load-use hazard,
// stall/flush priority, illegal opcodes and asynchronous reset.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        load_use_hazard;
  logic        ex_valid;
  logic [1:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_alu_src;
  logic        ex_branch;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc;
  logic        ex_illegal;

  int numChecks;
  int numFails;

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .load_use_hazard(load_use_hazard), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] d1,
                               input logic [31:0] d2);
    id_valid    = v;
    id_instr    = instr;
    id_pc       = pc;
    id_rs1_data = d1;
    id_rs2_data = d2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    assert (observed === expected)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence; inputs change 1 ns after a rising edge, outputs are checked there.
  initial begin
    numChecks = 0;
    numFails  = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b1, 32'h0000A303, 32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0);
    step();
    step();
    checkOutput("reset_valid", 32'(ex_valid), 0);
    checkOutput("reset_mem_read", 32'(ex_mem_read), 0);
    checkOutput("reset_rd", 32'(ex_rd), 0);
    checkOutput("reset_pc", ex_pc, 0);
    checkOutput("reset_imm", ex_imm, 0);
    checkOutput("reset_hazard", 32'(load_use_hazard), 0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h402081B3, 32'h0, 32'h0, 32'h0);
    step();
    checkOutput("idle_valid", 32'(ex_valid), 0);
    checkOutput("idle_reg_write", 32'(ex_reg_write), 0);

    // sub x3,x1,x2
    applyStimulus(1'b1, 32'h402081B3, 32'h100, 32'h11, 32'h22);
    step();
    checkOutput("sub_valid", 32'(ex_valid), 1);
    checkOutput("sub_alu_op", 32'(ex_alu_op), 2);
    checkOutput("sub_funct7", 32'(ex_funct7), 32'h20);
    checkOutput("sub_funct3", 32'(ex_funct3), 0);
    checkOutput("sub_rd", 32'(ex_rd), 3);
    checkOutput("sub_rs2", 32'(ex_rs2), 2);
    checkOutput("sub_reg_write", 32'(ex_reg_write), 1);
    checkOutput("sub_alu_src", 32'(ex_alu_src), 0);
    checkOutput("sub_rs1_data", ex_rs1_data, 32'h11);
    checkOutput("sub_pc", ex_pc, 32'h100);

    // addi x5,x0,-1
    applyStimulus(1'b1, 32'hFFF00293, 32'h104, 32'h0, 32'h0);
    step();
    checkOutput("addi_imm", ex_imm, 32'hFFFFFFFF);
    checkOutput("addi_alu_op", 32'(ex_alu_op), 3);
    checkOutput("addi_alu_src", 32'(ex_alu_src), 1);
    checkOutput("addi_reg_write", 32'(ex_reg_write), 1);

    // sw x2,8(x1)
    applyStimulus(1'b1, 32'h0020A423, 32'h108, 32'h0, 32'h0);
    step();
    checkOutput("sw_imm", ex_imm, 32'h8);
    checkOutput("sw_mem_write", 32'(ex_mem_write), 1);
    checkOutput("sw_reg_write", 32'(ex_reg_write), 0);
    checkOutput("sw_alu_op", 32'(ex_alu_op), 0);

    // beq x1,x2,-4
    applyStimulus(1'b1, 32'hFE208EE3, 32'h10C, 32'h0, 32'h0);
    step();
    checkOutput("beq_imm", ex_imm, 32'hFFFFFFFC);
    checkOutput("beq_alu_op", 32'(ex_alu_op), 1);
    checkOutput("beq_branch", 32'(ex_branch), 1);

    // lw x6,0(x1) then add x7,x6,x2: one bubble
    applyStimulus(1'b1, 32'h0000A303, 32'h110, 32'h0, 32'h0);
    checkOutput("lw_pre_hazard", 32'(load_use_hazard), 0);
    step();
    checkOutput("lw_mem_read", 32'(ex_mem_read), 1);
    checkOutput("lw_mem_to_reg", 32'(ex_mem_to_reg), 1);
    checkOutput("lw_rd", 32'(ex_rd), 6);
    applyStimulus(1'b1, 32'h002303B3, 32'h114, 32'h0, 32'h0);
    #1;
    checkOutput("lu_hazard_on", 32'(load_use_hazard), 1);
    step();
    checkOutput("lu_bubble_valid", 32'(ex_valid), 0);
    checkOutput("lu_bubble_reg_write", 32'(ex_reg_write), 0);
    checkOutput("lu_hazard_off", 32'(load_use_hazard), 0);
    step();
    checkOutput("lu_add_valid", 32'(ex_valid), 1);
    checkOutput("lu_add_rd", 32'(ex_rd), 7);
    checkOutput("lu_add_pc", ex_pc, 32'h114);

    // lw x6 then add x7,x0,x2: no dependence
    applyStimulus(1'b1, 32'h0000A303, 32'h118, 32'h0, 32'h0);
    step();
    applyStimulus(1'b1, 32'h002003B3, 32'h11C, 32'h0, 32'h0);
    #1;
    checkOutput("nodep_hazard", 32'(load_use_hazard), 0);
    step();
    checkOutput("nodep_valid", 32'(ex_valid), 1);
    checkOutput("nodep_rd", 32'(ex_rd), 7);

    // add x0,x1,x2: write to x0 suppressed
    applyStimulus(1'b1, 32'h00208033, 32'h120, 32'h0, 32'h0);
    step();
    checkOutput("x0_reg_write", 32'(ex_reg_write), 0);
    checkOutput("x0_valid", 32'(ex_valid), 1);

    // stall together with hazard: hold, hazard persists
    applyStimulus(1'b1, 32'h0000A303, 32'h124, 32'h0, 32'h0);
    step();
    applyStimulus(1'b1, 32'h002303B3, 32'h128, 32'h0, 32'h0);
    stall = 1'b1;
    step();
    checkOutput("sh_hold_mem_read", 32'(ex_mem_read), 1);
    checkOutput("sh_hold_pc", ex_pc, 32'h124);
    checkOutput("sh_hazard_kept", 32'(load_use_hazard), 1);
    stall = 1'b0;
    step();
    checkOutput("sh_bubble_valid", 32'(ex_valid), 0);
    step();
    checkOutput("sh_add_rd", 32'(ex_rd), 7);
    checkOutput("sh_add_pc", ex_pc, 32'h128);

    // stall three cycles: add x7 stays frozen
    applyStimulus(1'b1, 32'hFFF00293, 32'h200, 32'h55, 32'h66);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_rd", 32'(ex_rd), 7);
      checkOutput("stall_alu_op", 32'(ex_alu_op), 2);
      checkOutput("stall_pc", ex_pc, 32'h128);
      checkOutput("stall_valid", 32'(ex_valid), 1);
    end
    flush = 1'b1;
    step();
    checkOutput("flush_stall_valid", 32'(ex_valid), 0);
    checkOutput("flush_stall_reg_write", 32'(ex_reg_write), 0);
    flush = 1'b0;
    stall = 1'b0;
    step();
    checkOutput("resume_rd", 32'(ex_rd), 5);
    checkOutput("resume_valid", 32'(ex_valid), 1);

    // illegal opcode
    applyStimulus(1'b1, 32'h0000007F, 32'h300, 32'h0, 32'h0);
    step();
    checkOutput("ill_flag", 32'(ex_illegal), 1);
    checkOutput("ill_valid", 32'(ex_valid), 1);
    checkOutput("ill_alu_op", 32'(ex_alu_op), 0);
    checkOutput("ill_ctrl",
                32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                     ex_alu_src, ex_branch}), 0);
    applyStimulus(1'b0, 32'h0000007F, 32'h304, 32'h0, 32'h0);
    step();
    checkOutput("ill_invalid_flag", 32'(ex_illegal), 0);
    checkOutput("ill_invalid_valid", 32'(ex_valid), 0);

    // invalid load slot: control zeroed
    applyStimulus(1'b0, 32'h0000A303, 32'h308, 32'h0, 32'h0);
    step();
    checkOutput("inv_load_mem_read", 32'(ex_mem_read), 0);

    // asynchronous reset mid-operation
    applyStimulus(1'b1, 32'h0000A303, 32'h400, 32'h0, 32'h0);
    step();
    checkOutput("pre_rst_mem_read", 32'(ex_mem_read), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(ex_valid), 0);
    checkOutput("async_rst_mem_read", 32'(ex_mem_read), 0);
    checkOutput("async_rst_pc", ex_pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
